// File: rtl/proc_pkg.sv
// Shared encodings for the multi-cycle AR/T core: opcodes, ALU funcs, FSM states.
package proc_pkg;

  localparam logic [4:0] OP_AR   = 5'b00010;
  localparam logic [4:0] OP_T    = 5'b00011;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0010;
  localparam logic [3:0] F_OR  = 4'b0011;
  localparam logic [3:0] F_XOR = 4'b0100;
  localparam logic [3:0] F_SLL = 4'b0101;
  localparam logic [3:0] F_SRL = 4'b0110;
  localparam logic [3:0] F_SRA = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

endpackage

// File: rtl/proc_multicycle_if.sv
// Instruction-memory req/ack fetch port: the core is master, the memory is slave.
interface proc_multicycle_if #(
  parameter int PC_W = 32
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/proc_regfile.sv
// Register file: two async operand reads, one async debug read, one sync write.
module proc_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] dbg_addr,
  input  logic              we,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [2**REG_AW];

  assign rs1_data = mem[rs1_addr];
  assign rs2_data = mem[rs2_addr];
  assign dbg_data = mem[dbg_addr];

  // Clear every register on reset; otherwise write one register per enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_AW; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/proc_multicycle.sv
// Multi-cycle AR/T core: FETCH/DECODE/EXEC/WB sequencer with inline ALU,
// start/halt control, sticky illegal flag and carry flag.
module proc_multicycle
  import proc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 4,
  parameter int PC_W    = 32,
  parameter int PC_STEP = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [PC_W-1:0]   start_pc,
  proc_multicycle_if.master imem,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic              retire,
  output logic              carry,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int IMM_W = 23 - REG_AW;
  localparam int SH_W  = $clog2(DATA_W);

  state_t                    state;
  logic [31:0]               ir;
  logic signed [DATA_W-1:0]  op_a;
  logic signed [DATA_W-1:0]  op_b;
  logic signed [DATA_W-1:0]  result;
  logic [4:0]                opcode;
  logic [3:0]                func;
  logic [REG_AW-1:0]         rs1;
  logic [REG_AW-1:0]         rs2;
  logic [REG_AW-1:0]         rd;
  logic signed [IMM_W-1:0]   imm_f;
  logic signed [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]         rf_rs1;
  logic [DATA_W-1:0]         rf_rs2;

  assign opcode    = ir[31:27];
  assign func      = ir[26:23];
  assign rs1       = ir[22 -: REG_AW];
  assign rs2       = ir[22-REG_AW -: REG_AW];
  assign rd        = (opcode == OP_T) ? rs1 : ir[22-2*REG_AW -: REG_AW];
  assign imm_f     = ir[IMM_W-1:0];
  assign imm       = DATA_W'(imm_f);
  assign imem.addr = pc;

  // Only AR with a defined func, T and HALT are executable.
  function automatic logic is_legal(input logic [4:0] op, input logic [3:0] fn);
    return (op == OP_AR && !fn[3]) || op == OP_T || op == OP_HALT;
  endfunction

  // Returns {carry_out, result}; carry passes through for non-arithmetic ops.
  function automatic logic [DATA_W:0] alu(input logic [3:0] fn,
                                          input logic signed [DATA_W-1:0] a,
                                          input logic signed [DATA_W-1:0] b,
                                          input logic c_in);
    logic [SH_W-1:0]          sh;
    logic [DATA_W:0]          sum;
    logic signed [DATA_W-1:0] r;
    logic                     c;
    sh  = b[SH_W-1:0];
    sum = {1'b0, a} + {1'b0, b};
    r   = '0;
    c   = c_in;
    case (fn)
      F_ADD: begin r = sum[DATA_W-1:0]; c = sum[DATA_W]; end
      F_SUB: begin r = a - b; c = ($unsigned(a) >= $unsigned(b)); end
      F_AND: r = a & b;
      F_OR:  r = a | b;
      F_XOR: r = a ^ b;
      F_SLL: r = a << sh;
      F_SRL: r = $unsigned(a) >> sh;
      F_SRA: r = a >>> sh;
      default: r = '0;
    endcase
    return {c, r};
  endfunction

  proc_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
    .clk      (CLK),
    .rst_n    (RESET),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .dbg_addr (dbg_addr),
    .we       (state == WB),
    .wr_addr  (rd),
    .wr_data  (result),
    .rs1_data (rf_rs1),
    .rs2_data (rf_rs2),
    .dbg_data (dbg_data)
  );

  // Instruction sequencer with registered status/handshake outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      carry    <= 1'b0;
      illegal  <= 1'b0;
      imem.req <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      retire   <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc       <= start_pc;
            illegal  <= 1'b0;
            imem.req <= 1'b1;
            busy     <= 1'b1;
            halted   <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (imem.ack) begin
            ir       <= imem.rdata;
            imem.req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          op_a <= rf_rs1;
          op_b <= rf_rs2;
          if (!is_legal(opcode, func) || opcode == OP_HALT) begin
            illegal <= !is_legal(opcode, func);
            busy    <= 1'b0;
            halted  <= 1'b1;
            state   <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (opcode == OP_AR) {carry, result} <= alu(func, op_a, op_b, carry);
          else                 result <= imm;
          retire <= 1'b1;
          state  <= WB;
        end
        WB: begin
          pc       <= pc + PC_W'(PC_STEP);
          imem.req <= 1'b1;
          state    <= FETCH;
        end
        default: begin
          imem.req <= 1'b0;
          busy     <= 1'b0;
          halted   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_multicycle.sv
// Directed bench for proc_multicycle: instruction-level model plus literal pins,
// and a second 16-bit / 8-register build exercising the shifted field layout.
module tb_proc_multicycle;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        start, start2;
  logic [31:0] start_pc, start_pc2;
  logic [31:0] pc, pc2;
  logic        busy, halted, illegal, retire, carry;
  logic        busy2, halted2, illegal2, retire2, carry2;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [2:0]  dbg_addr2;
  logic [15:0] dbg_data2;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  logic [31:0] m_reg [16];
  logic [31:0] m_pc;
  logic        m_carry, m_illegal;

  always #5 CLK = ~CLK;

  proc_multicycle_if #(.PC_W(32)) imem ();
  proc_multicycle_if #(.PC_W(32)) imem2 ();

  proc_multicycle #(.DATA_W(32), .REG_AW(4), .PC_W(32), .PC_STEP(4)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .start_pc(start_pc), .imem(imem),
    .pc(pc), .busy(busy), .halted(halted), .illegal(illegal), .retire(retire),
    .carry(carry), .dbg_addr(dbg_addr), .dbg_data(dbg_data));

  proc_multicycle #(.DATA_W(16), .REG_AW(3), .PC_W(32), .PC_STEP(4)) dut2 (
    .CLK(CLK), .RESET(RESET), .start(start2), .start_pc(start_pc2), .imem(imem2),
    .pc(pc2), .busy(busy2), .halted(halted2), .illegal(illegal2), .retire(retire2),
    .carry(carry2), .dbg_addr(dbg_addr2), .dbg_data(dbg_data2));

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_pc = '0; m_carry = 1'b0; m_illegal = 1'b0;
  endtask

  // Architectural effect of one instruction, from the instruction-set rules.
  task automatic model_step(input logic [31:0] w, output bit halts, output int rdx);
    logic [31:0] a, b, res;
    logic [32:0] s;
    int          sh;
    a = m_reg[w[22:19]];
    b = m_reg[w[18:15]];
    sh = int'(b[4:0]);
    halts = 1'b0;
    rdx = 0;
    res = '0;
    if (w[31:27] == 5'b00011) begin
      rdx = int'(w[22:19]);
      m_reg[rdx] = {{13{w[18]}}, w[18:0]};
      m_pc = m_pc + 32'd4;
    end else if (w[31:27] == 5'b00010 && w[26] == 1'b0) begin
      rdx = int'(w[14:11]);
      case (w[25:23])
        3'd0: begin s = {1'b0, a} + {1'b0, b}; res = s[31:0]; m_carry = s[32]; end
        3'd1: begin res = a - b; m_carry = (a >= b); end
        3'd2: res = a & b;
        3'd3: res = a | b;
        3'd4: res = a ^ b;
        3'd5: res = a << sh;
        3'd6: res = a >> sh;
        default: res = $signed(a) >>> sh;
      endcase
      m_reg[rdx] = res;
      m_pc = m_pc + 32'd4;
    end else if (w[31:27] == 5'b11111) begin
      halts = 1'b1;
    end else begin
      halts = 1'b1;
      m_illegal = 1'b1;
    end
  endtask

  // Continuous check against the model whenever the core is fetching or halted.
  always @(negedge CLK) begin
    if (chk_on && RESET) begin
      if (imem.req) begin
        chk32("fetch_pc", pc, m_pc);
        chk32("fetch_addr", imem.addr, m_pc);
        chk1("fetch_carry", carry, m_carry);
        chk1("fetch_illegal", illegal, m_illegal);
        chk1("fetch_busy", busy, 1'b1);
        chk1("fetch_halted", halted, 1'b0);
      end else if (halted) begin
        chk32("halt_pc", pc, m_pc);
        chk1("halt_illegal", illegal, m_illegal);
        chk1("halt_busy", busy, 1'b0);
      end
    end
  end

  task automatic do_start(input logic [31:0] spc);
    @(negedge CLK);
    start = 1'b1; start_pc = spc;
    @(posedge CLK);
    m_pc = spc; m_illegal = 1'b0;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk32("reg_sweep", dbg_data, m_reg[i]);
    end
  endtask

  // Serve one fetch after dly wait states, then follow the instruction to completion.
  task automatic issue(input logic [31:0] w, input int dly, input bit stray);
    int n;
    bit halts;
    int rdx;
    n = 0;
    while (!imem.req && n < 50) begin @(negedge CLK); n++; end
    chk1("req_wait", imem.req, 1'b1);
    for (int i = 0; i < dly; i++) begin
      imem.rdata = $urandom;
      start = (i == 0 && dly >= 2);
      start_pc = 32'hDEAD0;
      @(negedge CLK);
      start = 1'b0;
    end
    imem.ack = 1'b1; imem.rdata = w;
    @(posedge CLK);
    model_step(w, halts, rdx);
    @(negedge CLK);
    imem.ack = stray; imem.rdata = $urandom;
    chk1("retire_decode", retire, 1'b0);
    @(negedge CLK);
    imem.ack = 1'b0;
    if (halts) begin
      chk1("halt_reached", halted, 1'b1);
      chk1("retire_halt", retire, 1'b0);
    end else begin
      chk1("retire_exec", retire, 1'b0);
      @(negedge CLK);
      chk1("retire_wb", retire, 1'b1);
      dbg_addr = 4'(rdx);
      @(negedge CLK);
      chk32("dbg_rd", dbg_data, m_reg[rdx]);
    end
  endtask

  task automatic feed2(input logic [31:0] w);
    int n;
    n = 0;
    while (!imem2.req && n < 50) begin @(negedge CLK); n++; end
    chk1("dut2_req", imem2.req, 1'b1);
    imem2.ack = 1'b1; imem2.rdata = w;
    @(negedge CLK);
    imem2.ack = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    start = 1'b0; start_pc = '0; start2 = 1'b0; start_pc2 = '0;
    imem.ack = 1'b0; imem.rdata = '0; imem2.ack = 1'b0; imem2.rdata = '0;
    dbg_addr = '0; dbg_addr2 = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk32("rst_pc", pc, 32'h0);
    chk1("rst_req", imem.req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chk1("rst_carry", carry, 1'b0);
    chk1("rst_retire", retire, 1'b0);
    check_regs();
    RESET = 1'b1;
    @(negedge CLK);
    chk1("idle_req", imem.req, 1'b0);
    chk_on = 1'b1;

    do_start(32'h100);
    chk32("first_addr", imem.addr, 32'h100);
    chk1("first_req", imem.req, 1'b1);
    issue(32'h18080005, 0, 1'b0);
    chk32("pc_after_wb", pc, 32'h104);
    dbg_addr = 4'd1; #1 chk32("r1_lit", dbg_data, 32'h5);
    issue(32'h1817FFFD, 5, 1'b0);
    dbg_addr = 4'd2; #1 chk32("r2_lit", dbg_data, 32'hFFFFFFFD);
    issue(32'h10091800, 0, 1'b1);
    dbg_addr = 4'd3; #1 chk32("r3_add_lit", dbg_data, 32'h2);
    chk1("carry_add_lit", carry, 1'b1);
    issue(32'h10892000, 2, 1'b0);
    dbg_addr = 4'd4; #1 chk32("r4_sub_lit", dbg_data, 32'h8);
    chk1("carry_sub_lit", carry, 1'b0);
    issue(32'h18280001, 0, 1'b0);
    issue(32'h1830001F, 1, 1'b0);
    issue(32'h12AB3800, 0, 1'b0);
    dbg_addr = 4'd7; #1 chk32("r7_sll_lit", dbg_data, 32'h80000000);
    issue(32'h18400004, 0, 1'b0);
    issue(32'h13BC4800, 0, 1'b0);
    dbg_addr = 4'd9; #1 chk32("r9_sra_lit", dbg_data, 32'hF8000000);
    issue(32'h1114D000, 0, 1'b0);
    issue(32'h10088800, 0, 1'b0);
    dbg_addr = 4'd1; #1 chk32("r1_self_add_lit", dbg_data, 32'hA);
    chk32("pc_lit", pc, 32'h12C);

    issue(32'h38000000, 0, 1'b0);
    chk1("illegal_lit", illegal, 1'b1);
    check_regs();
    do_start(32'h200);
    chk32("restart_pc", pc, 32'h200);
    chk1("restart_illegal", illegal, 1'b0);
    issue(32'h18580007, 0, 1'b0);
    issue(32'h14000000, 0, 1'b0);
    chk1("illegal_func", illegal, 1'b1);
    do_start(32'h240);
    issue(32'hF8000000, 0, 1'b0);
    chk1("halt_op_illegal", illegal, 1'b0);
    check_regs();

    do_start(32'h300);
    chk_on = 1'b0;
    imem.ack = 1'b1; imem.rdata = 32'h10095800;
    @(negedge CLK);
    imem.ack = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk32("abort_pc", pc, 32'h0);
    chk1("abort_carry", carry, 1'b0);
    chk1("abort_req", imem.req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk1("abort_retire", retire, 1'b0);
    end
    dbg_addr = 4'd11; #1 chk32("abort_rd", dbg_data, 32'h0);
    RESET = 1'b1;
    @(negedge CLK);
    chk1("abort_idle_req", imem.req, 1'b0);

    @(negedge CLK);
    start2 = 1'b1; start_pc2 = 32'h40;
    @(negedge CLK);
    start2 = 1'b0;
    feed2(32'h18100005);
    feed2(32'h182FFFFD);
    feed2(32'h1014C000);
    dbg_addr2 = 3'd1; #1 chk32("n16_r1", 32'(dbg_data2), 32'h5);
    dbg_addr2 = 3'd2; #1 chk32("n16_r2", 32'(dbg_data2), 32'hFFFD);
    dbg_addr2 = 3'd3; #1 chk32("n16_r3", 32'(dbg_data2), 32'h2);
    chk1("n16_carry", carry2, 1'b1);
    chk32("n16_pc", pc2, 32'h4C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
